// File: rtl/mdio_phy_slave.sv
// MDIO (clause 22) PHY management slave: synchronises MDC/MDIO into the clk
// domain, decodes read/write frames addressed to PHY_ADDR and serves a
// 32 x 16 register file with read-only PHY ID registers at 0x02/0x03.
module mdio_phy_slave #(
    parameter logic [4:0]  PHY_ADDR    = 5'h01,
    parameter logic [15:0] PHYID1      = 16'h2000,
    parameter logic [15:0] PHYID2      = 16'h5C90,
    parameter logic [15:0] REG18_RESET = 16'h0036
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_t,
    output logic        wr_valid,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data
);

    typedef enum logic [2:0] {
        IDLE, START, OP, PHYAD, REGAD, TA, RD_DATA, WR_DATA
    } state_t;

    state_t      state, state_n;
    logic [5:0]  cnt, cnt_n;
    logic        op_hi, op_hi_n;
    logic        op_rd, op_rd_n;
    logic        match, match_n;
    logic [4:0]  phyad, phyad_n;
    logic [4:0]  regad, regad_n;
    logic [15:0] shreg, shreg_n;
    logic        mdio_o_n, mdio_t_n;
    logic        wr_valid_n;
    logic [4:0]  wr_addr_n;
    logic [15:0] wr_data_n;
    logic        reg_we;
    logic [15:0] wr_word;
    logic [15:0] rd_word;

    logic        mdc_s1, mdc_s2, mdc_q;
    logic        mdio_s1, mdio_s2;
    logic        bit_evt;
    logic        bit_val;

    logic [15:0] regs [32];

    // Two-flop synchronisers plus a delayed copy of MDC for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mdc_s1  <= 1'b0;
            mdc_s2  <= 1'b0;
            mdc_q   <= 1'b0;
            mdio_s1 <= 1'b0;
            mdio_s2 <= 1'b0;
        end else begin
            mdc_s1  <= mdc;
            mdc_s2  <= mdc_s1;
            mdc_q   <= mdc_s2;
            mdio_s1 <= mdio_i;
            mdio_s2 <= mdio_s1;
        end
    end

    assign bit_evt = mdc_s2 & ~mdc_q;
    assign bit_val = mdio_s2;
    assign wr_word = {shreg[14:0], bit_val};

    // Read mux: ID registers come from parameters, not from storage
    always_comb begin
        case (regad)
            5'h02:   rd_word = PHYID1;
            5'h03:   rd_word = PHYID2;
            default: rd_word = regs[regad];
        endcase
    end

    // Frame state and all registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            op_hi    <= 1'b0;
            op_rd    <= 1'b0;
            match    <= 1'b0;
            phyad    <= '0;
            regad    <= '0;
            shreg    <= '0;
            mdio_o   <= 1'b1;
            mdio_t   <= 1'b1;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            op_hi    <= op_hi_n;
            op_rd    <= op_rd_n;
            match    <= match_n;
            phyad    <= phyad_n;
            regad    <= regad_n;
            shreg    <= shreg_n;
            mdio_o   <= mdio_o_n;
            mdio_t   <= mdio_t_n;
            wr_valid <= wr_valid_n;
            wr_addr  <= wr_addr_n;
            wr_data  <= wr_data_n;
        end
    end

    // Next-state decode; everything advances only on an MDC bit event.
    // cnt doubles as preamble counter in IDLE and bit index elsewhere.
    // Non-matching frames walk the same TA/data states with match=0 so the
    // bit count stays aligned while the line and wr_valid stay quiet.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        op_hi_n    = op_hi;
        op_rd_n    = op_rd;
        match_n    = match;
        phyad_n    = phyad;
        regad_n    = regad;
        shreg_n    = shreg;
        mdio_o_n   = mdio_o;
        mdio_t_n   = mdio_t;
        wr_valid_n = 1'b0;
        wr_addr_n  = wr_addr;
        wr_data_n  = wr_data;
        reg_we     = 1'b0;

        if (bit_evt) begin
            case (state)
                IDLE: begin
                    if (bit_val) begin
                        if (cnt != 6'd32) cnt_n = cnt + 6'd1;
                    end else if (cnt == 6'd32) begin
                        state_n = START;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = '0;
                    end
                end
                START: begin
                    state_n = bit_val ? OP : IDLE;
                    cnt_n   = '0;
                end
                OP: begin
                    if (cnt == 6'd0) begin
                        op_hi_n = bit_val;
                        cnt_n   = 6'd1;
                    end else begin
                        cnt_n = '0;
                        if (op_hi && !bit_val) begin
                            op_rd_n = 1'b1;
                            state_n = PHYAD;
                        end else if (!op_hi && bit_val) begin
                            op_rd_n = 1'b0;
                            state_n = PHYAD;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
                PHYAD: begin
                    phyad_n = {phyad[3:0], bit_val};
                    if (cnt == 6'd4) begin
                        match_n = ({phyad[3:0], bit_val} == PHY_ADDR);
                        state_n = REGAD;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 6'd1;
                    end
                end
                REGAD: begin
                    regad_n = {regad[3:0], bit_val};
                    if (cnt == 6'd4) begin
                        state_n = TA;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 6'd1;
                    end
                end
                TA: begin
                    if (cnt == 6'd0) begin
                        if (op_rd && match) begin
                            mdio_t_n = 1'b0;
                            mdio_o_n = 1'b0;
                        end
                        cnt_n = 6'd1;
                    end else begin
                        cnt_n = '0;
                        if (op_rd) begin
                            if (match) begin
                                mdio_o_n = rd_word[15];
                                shreg_n  = {rd_word[14:0], 1'b0};
                            end
                            state_n = RD_DATA;
                        end else begin
                            state_n = WR_DATA;
                        end
                    end
                end
                RD_DATA: begin
                    if (cnt == 6'd15) begin
                        mdio_t_n = 1'b1;
                        mdio_o_n = 1'b1;
                        state_n  = IDLE;
                        cnt_n    = '0;
                    end else begin
                        if (match) begin
                            mdio_o_n = shreg[15];
                            shreg_n  = {shreg[14:0], 1'b0};
                        end
                        cnt_n = cnt + 6'd1;
                    end
                end
                WR_DATA: begin
                    shreg_n = wr_word;
                    if (cnt == 6'd15) begin
                        if (match) begin
                            wr_valid_n = 1'b1;
                            wr_addr_n  = regad;
                            wr_data_n  = wr_word;
                            reg_we     = (regad != 5'h02) && (regad != 5'h03);
                        end
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 6'd1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Register file: changes only on reset or a committed write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs     <= '{default: '0};
            regs[24] <= REG18_RESET;
        end else if (reg_we) begin
            regs[regad] <= wr_word;
        end
    end

endmodule

// File: tb/tb_mdio_phy_slave.sv
// Self-checking bench for mdio_phy_slave: bit-banged MDIO master, register
// model feeding expected-value queues for reads and write commits.
module tb_mdio_phy_slave;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mdc = 1'b0;
    logic        mdio_i = 1'b1;
    logic        mdio_o;
    logic        mdio_t;
    logic        wr_valid;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_wr     = 0;

    logic [15:0] rd_q [$];
    logic [20:0] wr_q [$];
    logic [15:0] model [32];
    logic        t_low_seen = 1'b0;
    logic        prev_wv = 1'b0;

    mdio_phy_slave #(
        .PHY_ADDR   (5'h01),
        .PHYID1     (16'h2000),
        .PHYID2     (16'h5C90),
        .REG18_RESET(16'h0036)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .mdc     (mdc),
        .mdio_i  (mdio_i),
        .mdio_o  (mdio_o),
        .mdio_t  (mdio_t),
        .wr_valid(wr_valid),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = 16'h0000;
        model[24] = 16'h0036;
    endtask

    function automatic logic [15:0] model_read(input logic [4:0] ra);
        if (ra == 5'h02) return 16'h2000;
        if (ra == 5'h03) return 16'h5C90;
        return model[ra];
    endfunction

    // Write-commit monitor and drive watcher
    always @(negedge clk) begin
        logic [20:0] e;
        if (!mdio_t) t_low_seen = 1'b1;
        if (wr_valid) begin
            n_wr++;
            check_eq("wr_pulse_1clk", {31'd0, prev_wv}, 32'd0);
            if (wr_q.size() == 0) begin
                check_eq("wr_unexpected", {27'd0, wr_addr}, 32'hFFFF_FFFF);
            end else begin
                e = wr_q.pop_front();
                check_eq("wr_addr", {27'd0, wr_addr}, {27'd0, e[20:16]});
                check_eq("wr_data", {16'd0, wr_data}, {16'd0, e[15:0]});
            end
        end
        prev_wv = wr_valid;
    end

    // One MDC period; line state is sampled just before the rising edge
    task automatic send_bit(input logic b, output logic t, output logic o);
        mdc = 1'b0;
        mdio_i = b;
        repeat (4) @(negedge clk);
        t = mdio_t;
        o = mdio_o;
        mdc = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic preamble(input int n);
        logic t, o;
        for (int i = 0; i < n; i++) send_bit(1'b1, t, o);
    endtask

    task automatic do_frame(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] ra,
                            input logic [15:0] wd, input int n_data,
                            output logic [15:0] got, output logic drv_ok);
        logic [13:0] hdr;
        logic t, o;
        hdr = {2'b01, op, phy, ra};
        got = '0;
        drv_ok = 1'b1;
        for (int i = 13; i >= 0; i--) send_bit(hdr[i], t, o);
        if (op == 2'b10) begin
            send_bit(1'b1, t, o);
            send_bit(1'b1, t, o);
            if (t !== 1'b0 || o !== 1'b0) drv_ok = 1'b0;
            for (int i = 0; i < n_data; i++) begin
                send_bit(1'b1, t, o);
                got = {got[14:0], o};
                if (t !== 1'b0) drv_ok = 1'b0;
            end
        end else begin
            send_bit(1'b1, t, o);
            send_bit(1'b0, t, o);
            for (int i = 0; i < n_data; i++) send_bit(wd[15 - i], t, o);
        end
    endtask

    task automatic wr_frame(input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] d);
        logic [15:0] g;
        logic ok;
        preamble(32);
        t_low_seen = 1'b0;
        if (phy == 5'h01) begin
            wr_q.push_back({ra, d});
            if (ra != 5'h02 && ra != 5'h03) model[ra] = d;
        end
        do_frame(2'b01, phy, ra, d, 16, g, ok);
        repeat (4) @(negedge clk);
        check_eq("wr_no_drive", {31'd0, t_low_seen}, 32'd0);
    endtask

    task automatic rd_frame(input logic [4:0] phy, input logic [4:0] ra);
        logic [15:0] g;
        logic ok;
        preamble(32);
        t_low_seen = 1'b0;
        if (phy == 5'h01) rd_q.push_back(model_read(ra));
        do_frame(2'b10, phy, ra, 16'h0000, 16, g, ok);
        repeat (2) @(negedge clk);
        check_eq("rd_release", {31'd0, mdio_t}, 32'd1);
        if (phy == 5'h01) begin
            check_eq("rd_drive", {31'd0, ok}, 32'd1);
            check_eq("rd_data", {16'd0, g}, {16'd0, rd_q.pop_front()});
        end else begin
            check_eq("rd_foreign_quiet", {31'd0, t_low_seen}, 32'd0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] g;
        logic ok;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_mdio_t", {31'd0, mdio_t}, 32'd1);
        check_eq("rst_mdio_o", {31'd0, mdio_o}, 32'd1);
        check_eq("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
        check_eq("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
        check_eq("rst_wr_data", {16'd0, wr_data}, 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        rd_frame(5'h01, 5'h18);
        wr_frame(5'h01, 5'h04, 16'hA5C3);
        rd_frame(5'h01, 5'h04);
        wr_frame(5'h01, 5'h02, 16'hFFFF);
        rd_frame(5'h01, 5'h02);
        rd_frame(5'h01, 5'h03);
        wr_frame(5'h01, 5'h1F, 16'h1234);
        wr_frame(5'h01, 5'h00, 16'h8001);
        rd_frame(5'h01, 5'h1F);
        rd_frame(5'h01, 5'h00);

        rd_frame(5'h07, 5'h18);
        rd_frame(5'h01, 5'h18);
        wr_frame(5'h07, 5'h05, 16'hBEEF);
        rd_frame(5'h01, 5'h05);

        // 31-bit preamble: frame must be ignored
        preamble(31);
        t_low_seen = 1'b0;
        do_frame(2'b10, 5'h01, 5'h18, 16'h0000, 16, g, ok);
        repeat (4) @(negedge clk);
        check_eq("short_pre_quiet", {31'd0, t_low_seen}, 32'd0);

        // OP=11 frame must be ignored
        preamble(32);
        t_low_seen = 1'b0;
        do_frame(2'b11, 5'h01, 5'h04, 16'h0000, 16, g, ok);
        repeat (4) @(negedge clk);
        check_eq("bad_op_quiet", {31'd0, t_low_seen}, 32'd0);
        rd_frame(5'h01, 5'h04);

        // Reset in the middle of a read drive
        preamble(32);
        do_frame(2'b10, 5'h01, 5'h18, 16'h0000, 8, g, ok);
        check_eq("mid_rd_drive", {31'd0, mdio_t}, 32'd0);
        check_eq("mid_rd_hi_byte", {24'd0, g[7:0]}, {24'd0, model_read(5'h18) >> 8});
        #2;
        reset = 1'b0;
        #1;
        check_eq("async_release", {31'd0, mdio_t}, 32'd1);
        model_reset();
        mdc = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        rd_frame(5'h01, 5'h18);
        rd_frame(5'h01, 5'h04);

        repeat (10) @(negedge clk);
        check_eq("wr_q_drained", wr_q.size(), 32'd0);
        check_eq("wr_pulse_count", n_wr, 32'd4);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mdio_phy_slave.md
MDIO_PHY_SLAVE -- requirements
Module: mdio_phy_slave

Interface
REQ-001 SHALL have parameter PHY_ADDR, default 5'h01: PHY address this block answers to.
REQ-002 SHALL have parameter PHYID1, default 16'h2000: read-only value of register 0x02.
REQ-003 SHALL have parameter PHYID2, default 16'h5C90: read-only value of register 0x03.
REQ-004 SHALL have parameter REG18_RESET, default 16'h0036: reset value of register 0x18 (LED control).
REQ-005 SHALL have port clk, input, 1: system clock; all logic is in this single clock domain.
REQ-006 SHALL have port reset, input, 1: reset is asynchronous and active-low.
REQ-007 SHALL have port mdc, input, 1: management clock from the MDIO master, asynchronous to clk.
REQ-008 SHALL have port mdio_i, input, 1: sampled MDIO line.
REQ-009 SHALL have port mdio_o, output, 1: MDIO drive value.
REQ-010 SHALL have port mdio_t, output, 1: tristate enable, 1 = released (high-Z), 0 = driving mdio_o.
REQ-011 SHALL have port wr_valid, output, 1: one-clk pulse when a register write commits.
REQ-012 SHALL have ports wr_addr, output, 5 and wr_data, output, 16: register address and data of the committed write, valid while wr_valid=1.

Function
REQ-013 SHALL pass mdc and mdio_i through 2-flop synchronizers and detect an MDC rising edge as a 0->1 transition of synchronized mdc; operation is guaranteed for MDC high and low times >= 3 clk.
REQ-014 SHALL sample synchronized MDIO only on a detected MDC rising edge ("bit event").
REQ-015 SHALL hold a 32 x 16 register file; all registers reset to 0 except 0x18 = REG18_RESET; registers 0x02/0x03 read PHYID1/PHYID2 and ignore writes.
REQ-016 SHALL implement states IDLE, START, OP, PHYAD, REGAD, TA, RD_DATA, WR_DATA.
REQ-017 IDLE: SHALL count consecutive 1 bits, saturating at 32; a 0 bit with count < 32 clears the count; a 0 bit with count = 32 moves to START.
REQ-018 START: bit 1 -> OP; bit 0 -> IDLE with preamble count cleared.
REQ-019 OP: SHALL capture 2 bits MSB first; 2'b10 = read, 2'b01 = write; any other value -> IDLE, count cleared, no line drive.
REQ-020 PHYAD then REGAD: SHALL capture 5 bits each, MSB first.
REQ-021 TA on read with PHYAD == PHY_ADDR: during the clk cycle following the TA-bit-1 event, SHALL set mdio_t=0, mdio_o=0; SHALL shift register[REGAD] out MSB first, changing mdio_o in the clk cycle after each subsequent bit event (D15 after the TA-bit-2 event ... D0 after the D1 event).
REQ-022 RD_DATA: SHALL set mdio_t=1 in the clk cycle after the D0 event and return to IDLE with count cleared.
REQ-023 Write with matching PHYAD: SHALL skip 2 TA bits without checking them, capture 16 data bits MSB first, and in the clk cycle after the D0 event update the register (unless read-only) and pulse wr_valid=1 for exactly one clk with wr_addr/wr_data; read-only targets still pulse wr_valid.
REQ-024 PHYAD != PHY_ADDR: SHALL keep mdio_t=1 and wr_valid=0 for the whole frame, count the remaining TA+16 bits, then return to IDLE.
REQ-025 Every completed or aborted frame SHALL require a fresh 32-bit preamble before the next START is recognised.
REQ-026 mdio_t SHALL be 0 only between the TA-bit-1 event and the end of the D0 drive of a matching read; at all other times it SHALL be 1.
REQ-027 MDC stopping mid-frame SHALL hold the state indefinitely; there is no timeout.
REQ-028 Register file content SHALL change only via committed writes or reset.

Reset
REQ-029 While reset=0: SHALL force state IDLE, preamble count 0, mdio_t=1, mdio_o=1, wr_valid=0, wr_addr=0, wr_data=0, synchronizers to 0, register file to REQ-015 values.
REQ-030 Reset asserted mid-frame, including mid-read drive, SHALL release MDIO (mdio_t=1) asynchronously; after deassertion a full preamble is required.

Verification
REQ-031 32x1 preamble, read PHYAD=1 REGAD=0x18 -> mdio_t low from TA bit 2 through D0, bits shifted out = 16'h0036, then mdio_t=1.
REQ-032 Write PHYAD=1 REGAD=0x04 data 16'hA5C3, then read 0x04 -> one wr_valid pulse with wr_addr=0x04, wr_data=16'hA5C3; read returns 16'hA5C3.
REQ-033 Write 16'hFFFF to 0x02, then read 0x02 -> wr_valid pulses; read returns 16'h2000.
REQ-034 Read with PHYAD=5'h07 -> mdio_t stays 1 for the entire frame; a following valid frame is still answered correctly.
REQ-035 31-bit preamble then valid read frame -> no response (mdio_t=1 throughout); frame with OP=2'b11 -> ignored, no wr_valid.
REQ-036 reset=0 asserted after D8 of a read -> mdio_t=1 immediately; after release, register 0x18 reads 16'h0036 and previously written 0x04 reads 16'h0000.
